// File: rtl/fibo_datapath.sv
`default_nettype none
// ============================================================================
// Module   : fibo_datapath
// Purpose  : Register file (R0..R3) plus 3-bit-opcode ALU that executes the
//            Fibonacci controller's per-cycle control word. Returns a
//            registered zero flag and a sticky overflow/borrow flag; R3 is
//            presented directly as the result.
// Options  : FIBO_DP_SAT_EN - when defined, add/increment saturate to
//            all-ones on carry and sub/decrement clamp to zero on borrow.
//            Undefined (default): arithmetic wraps modulo 2^WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module fibo_datapath #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_data,
   input  logic [2:0]       alu_opcode,
   input  logic [1:0]       rd_addr1,
   input  logic [1:0]       rd_addr2,
   input  logic [1:0]       wrt_addr,
   input  logic             wrt_en,
   output logic             zero_flag,
   output logic             ovf,
   output logic [WIDTH-1:0] result
);

   localparam logic [2:0] c_OP_PASS_A = 3'b000;
   localparam logic [2:0] c_OP_ADD    = 3'b001;
   localparam logic [2:0] c_OP_SUB    = 3'b010;
   localparam logic [2:0] c_OP_DEC    = 3'b011;
   localparam logic [2:0] c_OP_INC    = 3'b100;
   localparam logic [2:0] c_OP_ZERO   = 3'b101;
   localparam logic [2:0] c_OP_AND    = 3'b110;
   localparam logic [2:0] c_OP_PASS_B = 3'b111;

   localparam logic [WIDTH:0] c_ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH-1:0] regs_q [4];
   logic [WIDTH-1:0] regs_d [4];
   logic             zero_q, zero_d;
   logic             ovf_q,  ovf_d;

   logic [WIDTH-1:0] w_op_a;
   logic [WIDTH-1:0] w_op_b;
   logic [WIDTH:0]   w_alu_ext;     // extra top bit carries carry/borrow
   logic             w_is_add;      // op can carry out of the top bit
   logic             w_is_sub;      // op can borrow
   logic             w_carry;
   logic [WIDTH-1:0] w_alu_result;
   logic [WIDTH-1:0] w_wd;

   // Combinational register reads; a same-cycle write is not visible yet.
   assign w_op_a = regs_q[rd_addr1];
   assign w_op_b = regs_q[rd_addr2];

   // ALU: every op is evaluated one bit wider so carry/borrow falls out of bit WIDTH.
   always_comb begin
      w_alu_ext = '0;
      w_is_add  = 1'b0;
      w_is_sub  = 1'b0;
      case (alu_opcode)
         c_OP_PASS_A: w_alu_ext = {1'b0, w_op_a};
         c_OP_ADD: begin
            w_alu_ext = {1'b0, w_op_a} + {1'b0, w_op_b};
            w_is_add  = 1'b1;
         end
         c_OP_SUB: begin
            w_alu_ext = {1'b0, w_op_a} - {1'b0, w_op_b};
            w_is_sub  = 1'b1;
         end
         c_OP_DEC: begin
            w_alu_ext = {1'b0, w_op_a} - c_ONE_EXT;
            w_is_sub  = 1'b1;
         end
         c_OP_INC: begin
            w_alu_ext = {1'b0, w_op_a} + c_ONE_EXT;
            w_is_add  = 1'b1;
         end
         c_OP_ZERO:   w_alu_ext = '0;
         c_OP_AND:    w_alu_ext = {1'b0, w_op_a & w_op_b};
         c_OP_PASS_B: w_alu_ext = {1'b0, w_op_b};
         default:     w_alu_ext = '0;
      endcase
   end

   assign w_carry = (w_is_add | w_is_sub) & w_alu_ext[WIDTH];

   // Final ALU value: either wrap (drop the top bit) or saturate/clamp.
   always_comb begin
      w_alu_result = w_alu_ext[WIDTH-1:0];
`ifdef FIBO_DP_SAT_EN
      if (w_carry && w_is_add) begin
         w_alu_result = '1;
      end else if (w_carry && w_is_sub) begin
         w_alu_result = '0;
      end
`endif
   end

   assign w_wd = load_data ? data_in : w_alu_result;

   // Next-state: one register write plus flag update, only when enabled.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         regs_d[i] = regs_q[i];
      end
      zero_d = zero_q;
      ovf_d  = ovf_q;
      if (wrt_en) begin
         regs_d[wrt_addr] = w_wd;
         zero_d           = (w_wd == '0);
         if (load_data) begin
            ovf_d = 1'b0;
         end else if (w_carry) begin
            ovf_d = 1'b1;
         end
      end
   end

   // State register; asynchronous reset clears all architectural state at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
         zero_q <= 1'b1;
         ovf_q  <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= regs_d[i];
         end
         zero_q <= zero_d;
         ovf_q  <= ovf_d;
      end
   end

   assign zero_flag = zero_q;
   assign ovf       = ovf_q;
   assign result    = regs_q[3];

endmodule
`default_nettype wire

// File: tb/tb_fibo_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_fibo_datapath
// Purpose  : Self-checking bench for fibo_datapath: directed vector table,
//            Fibonacci and asynchronous-reset sequences, then random control
//            words checked against an arithmetic reference model.
// Options  : honours FIBO_DP_SAT_EN to match the saturating build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fibo_datapath;

   logic       clk;
   logic       rst_n;
   logic [7:0] data_in;
   logic       load_data;
   logic [2:0] alu_opcode;
   logic [1:0] rd_addr1;
   logic [1:0] rd_addr2;
   logic [1:0] wrt_addr;
   logic       wrt_en;
   logic       zero_flag;
   logic       ovf;
   logic [7:0] result;

   int n_checks = 0;
   int n_pass   = 0;

   fibo_datapath #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .load_data  (load_data),
      .alu_opcode (alu_opcode),
      .rd_addr1   (rd_addr1),
      .rd_addr2   (rd_addr2),
      .wrt_addr   (wrt_addr),
      .wrt_en     (wrt_en),
      .zero_flag  (zero_flag),
      .ovf        (ovf),
      .result     (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Build-dependent expectations for the directed table.
`ifdef FIBO_DP_SAT_EN
   localparam logic [7:0] c_ADD_OVF = 8'hFF;
   localparam logic [7:0] c_SUB_RES = 8'h00;
   localparam logic       c_SUB_Z   = 1'b1;
   localparam logic [7:0] c_DEC_RES = 8'h00;
   localparam logic       c_DEC_Z   = 1'b1;
   localparam logic [7:0] c_INC_RES = 8'h01;
   localparam logic       c_INC_Z   = 1'b0;
`else
   localparam logic [7:0] c_ADD_OVF = 8'h2C;
   localparam logic [7:0] c_SUB_RES = 8'h38;
   localparam logic       c_SUB_Z   = 1'b0;
   localparam logic [7:0] c_DEC_RES = 8'hFF;
   localparam logic       c_DEC_Z   = 1'b0;
   localparam logic [7:0] c_INC_RES = 8'h00;
   localparam logic       c_INC_Z   = 1'b1;
`endif

   typedef struct {
      logic       ld;
      logic [2:0] op;
      logic [1:0] a1;
      logic [1:0] a2;
      logic [1:0] wa;
      logic       we;
      logic [7:0] din;
      logic [7:0] er;
      logic       ez;
      logic       eo;
   } vec_t;

   vec_t tbl[$];

   // Reference model: plain integer arithmetic on an array of registers.
   int m_r[4];
   bit m_z;
   bit m_o;

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) m_r[i] = 0;
      m_z = 1'b1;
      m_o = 1'b0;
   endfunction

   function automatic void model_step(bit ld, int op, int a1, int a2, int wa, bit we, int din);
      int a, b, full, v;
      bit arith;
      a = m_r[a1];
      b = m_r[a2];
      arith = 1'b0;
      case (op)
         0: full = a;
         1: begin full = a + b; arith = 1'b1; end
         2: begin full = a - b; arith = 1'b1; end
         3: begin full = a - 1; arith = 1'b1; end
         4: begin full = a + 1; arith = 1'b1; end
         5: full = 0;
         6: full = a & b;
         default: full = b;
      endcase
`ifdef FIBO_DP_SAT_EN
      if (full > 255) v = 255;
      else if (full < 0) v = 0;
      else v = full;
`else
      v = full & 255;
`endif
      if (ld) v = din;
      if (we) begin
         m_r[wa] = v;
         m_z = (v == 0);
         if (ld) m_o = 1'b0;
         else if (arith && (full > 255 || full < 0)) m_o = 1'b1;
      end
   endfunction

   function automatic vec_t mk(bit ld, int op, int a1, int a2, int wa, bit we, int din,
                               int er, bit ez, bit eo);
      vec_t v;
      v.ld = ld; v.op = 3'(op); v.a1 = 2'(a1); v.a2 = 2'(a2); v.wa = 2'(wa);
      v.we = we; v.din = 8'(din); v.er = 8'(er); v.ez = ez; v.eo = eo;
      return v;
   endfunction

   task automatic chk(string nm, int got, int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
   endtask

   // Apply one control word for one cycle; the model sees the pre-edge state.
   task automatic step(bit ld, int op, int a1, int a2, int wa, bit we, int din);
      load_data  = ld;
      alu_opcode = 3'(op);
      rd_addr1   = 2'(a1);
      rd_addr2   = 2'(a2);
      wrt_addr   = 2'(wa);
      wrt_en     = we;
      data_in    = 8'(din);
      model_step(ld, op, a1, a2, wa, we, din);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_model(string nm);
      chk({nm, ".result"}, result, m_r[3]);
      chk({nm, ".zero"}, zero_flag, m_z);
      chk({nm, ".ovf"}, ovf, m_o);
   endtask

   int fib_exp[5] = '{2, 3, 5, 8, 13};

   initial begin
      rst_n = 1'b0; data_in = '0; load_data = 1'b0; alu_opcode = '0;
      rd_addr1 = '0; rd_addr2 = '0; wrt_addr = '0; wrt_en = 1'b0;
      model_reset();
      #12;
      chk("reset.result", result, 0);
      chk("reset.zero", zero_flag, 1);
      chk("reset.ovf", ovf, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Directed vectors: {ld, op, a1, a2, wa, we, din, exp result, exp zero, exp ovf}
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8'h07, 8'h00, 0, 0)); // load R0=7
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h09, 8'h00, 0, 0)); // load w/o enable: no-op
      tbl.push_back(mk(0, 0, 0, 0, 3, 1, 0, 8'h07, 0, 0));     // R3=R0 shows 7 kept
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8'h01, 8'h07, 0, 0)); // R0=1
      tbl.push_back(mk(0, 3, 0, 0, 0, 1, 0, 8'h07, 1, 0));     // R0=R0-1 -> 0
      tbl.push_back(mk(0, 0, 0, 0, 3, 1, 0, 8'h00, 1, 0));     // R3=R0
      tbl.push_back(mk(1, 0, 0, 0, 1, 1, 8'hC8, 8'h00, 0, 0)); // R1=C8
      tbl.push_back(mk(1, 0, 0, 0, 2, 1, 8'h64, 8'h00, 0, 0)); // R2=64
      tbl.push_back(mk(0, 1, 1, 2, 3, 1, 0, c_ADD_OVF, 0, 1)); // R3=R1+R2 overflow
      tbl.push_back(mk(0, 0, 2, 0, 0, 1, 0, c_ADD_OVF, 0, 1)); // ovf sticky
      tbl.push_back(mk(0, 5, 0, 0, 0, 0, 0, c_ADD_OVF, 0, 1)); // disabled write holds
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8'h00, c_ADD_OVF, 1, 0)); // load clears ovf
      tbl.push_back(mk(0, 2, 0, 1, 3, 1, 0, c_SUB_RES, c_SUB_Z, 1)); // 0-C8 borrow
      tbl.push_back(mk(1, 0, 0, 0, 2, 1, 8'h03, c_SUB_RES, 0, 0)); // R2=3
      tbl.push_back(mk(0, 4, 2, 0, 2, 1, 0, c_SUB_RES, 0, 0));  // R2=R2+1 -> 4
      tbl.push_back(mk(0, 4, 2, 0, 2, 1, 0, c_SUB_RES, 0, 0));  // R2=R2+1 -> 5
      tbl.push_back(mk(0, 0, 2, 0, 3, 1, 0, 8'h05, 0, 0));      // R3=R2
      tbl.push_back(mk(0, 1, 2, 2, 3, 1, 0, 8'h0A, 0, 0));      // A+A
      tbl.push_back(mk(0, 6, 1, 2, 3, 1, 0, 8'h00, 1, 0));      // C8 & 05
      tbl.push_back(mk(0, 7, 0, 1, 3, 1, 0, 8'hC8, 0, 0));      // pass B
      tbl.push_back(mk(0, 5, 1, 1, 1, 1, 0, 8'hC8, 1, 0));      // R1=0
      tbl.push_back(mk(0, 3, 1, 0, 3, 1, 0, c_DEC_RES, c_DEC_Z, 1)); // 0-1 borrow
      tbl.push_back(mk(0, 4, 3, 0, 3, 1, 0, c_INC_RES, c_INC_Z, 1)); // R3+1

      foreach (tbl[i]) begin
         step(tbl[i].ld, int'(tbl[i].op), int'(tbl[i].a1), int'(tbl[i].a2),
              int'(tbl[i].wa), tbl[i].we, int'(tbl[i].din));
         chk($sformatf("vec%0d.result", i), result, tbl[i].er);
         chk($sformatf("vec%0d.zero", i), zero_flag, tbl[i].ez);
         chk($sformatf("vec%0d.ovf", i), ovf, tbl[i].eo);
      end

      // Fibonacci iteration: R3=R1+R2, R1=R2, R2=R3.
      step(1, 0, 0, 0, 1, 1, 1);
      step(1, 0, 0, 0, 2, 1, 1);
      for (int k = 0; k < 5; k++) begin
         step(0, 1, 1, 2, 3, 1, 0);
         chk($sformatf("fib%0d", k), result, fib_exp[k]);
         step(0, 0, 2, 0, 1, 1, 0);
         step(0, 0, 3, 0, 2, 1, 0);
      end
      chk("fib.ovf", ovf, 0);

      // Asynchronous reset mid-cycle with live state and ovf set.
      step(1, 0, 0, 0, 1, 1, 8'h05);
      step(1, 0, 0, 0, 2, 1, 8'hFF);
      step(0, 1, 1, 2, 3, 1, 0);
      chk_model("pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst.result", result, 0);
      chk("arst.zero", zero_flag, 1);
      chk("arst.ovf", ovf, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(0, 0, 1, 0, 3, 1, 0);   // R1 must read back as cleared
      chk("arst.r1", result, 0);
      chk("arst.r1zero", zero_flag, 1);

      // Random control words against the reference model.
      for (int n = 0; n < 300; n++) begin
         int din;
         case ($urandom_range(0, 3))
            0: din = 0;
            1: din = $urandom_range(250, 255);
            default: din = $urandom_range(0, 255);
         endcase
         step(($urandom_range(0, 4) == 0), $urandom_range(0, 7), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 3) != 0), din);
         chk_model($sformatf("rnd%0d", n));
         if (n % 4 == 3) begin
            int src;
            src = $urandom_range(0, 2);
            step(0, 0, src, 0, 3, 1, 0);   // expose a non-result register through R3
            chk_model($sformatf("rndcp%0d", n));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
